cache_read_serializer: RTL and testbench



---
 rtl/cache_read_serializer.sv | 144 ++++++++++++++
 tb/tb_cache_read_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_read_serializer.sv
// Serializes IWIDTH cache read words into OWIDTH sub-beats, low sub-word first, with a registered done pulse.
// Optional macro CACHE_READ_SERIALIZER_PARTIAL_EN adds IN_words to emit only the first IN_words sub-beats.
module cache_read_serializer #(
  parameter int IWIDTH = 128,
  parameter int OWIDTH = 32,
  parameter int ID_LEN = 2,
  localparam int WNUM  = IWIDTH / OWIDTH,
  localparam int CW    = $clog2(WNUM) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_valid,
  output logic              OUT_ready,
  input  logic [ID_LEN-1:0] IN_id,
  input  logic [IWIDTH-1:0] IN_data,
  input  logic              IN_last,
`ifdef CACHE_READ_SERIALIZER_PARTIAL_EN
  input  logic [CW-1:0]     IN_words,
`endif
  input  logic              IN_ready,
  output logic              OUT_valid,
  output logic [ID_LEN-1:0] OUT_id,
  output logic [OWIDTH-1:0] OUT_data,
  output logic              OUT_last,
  output logic              OUT_doneValid,
  output logic [ID_LEN-1:0] OUT_doneId
);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] MAXWORDS = CW'(WNUM);

  logic              hold_valid_q, hold_valid_d;
  logic [IWIDTH-1:0] hold_data_q,  hold_data_d;
  logic [ID_LEN-1:0] hold_id_q,    hold_id_d;
  logic              hold_last_q,  hold_last_d;
  logic [CW-1:0]     hold_words_q, hold_words_d;
  logic [CW-1:0]     sub_idx_q,    sub_idx_d;
  logic              done_valid_q, done_valid_d;
  logic [ID_LEN-1:0] done_id_q,    done_id_d;

  logic              fire;
  logic              final_sub;
  logic              accept;
  logic              out_ready;
  logic              out_last;
  logic [CW-1:0]     words_in;
  logic [OWIDTH-1:0] out_data;

`ifdef CACHE_READ_SERIALIZER_PARTIAL_EN
  assign words_in = IN_words;
`else
  assign words_in = MAXWORDS;
`endif

  always_comb begin
    out_data = '0;
    for (int i = 0; i < WNUM; i++) begin
      if (sub_idx_q == CW'(i)) out_data = hold_data_q[i*OWIDTH +: OWIDTH];
    end
  end

  // The ready path is combinational through IN_ready so a new word can
  // replace the held one on the same edge its final sub-beat leaves.
  always_comb begin
    final_sub = (sub_idx_q == (hold_words_q - ONE));
    fire      = hold_valid_q && IN_ready;
    out_last  = hold_last_q && final_sub;
    out_ready = !hold_valid_q || (fire && final_sub);
    accept    = IN_valid && out_ready;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_id_d    = hold_id_q;
    hold_last_d  = hold_last_q;
    hold_words_d = hold_words_q;
    sub_idx_d    = sub_idx_q;
    done_valid_d = fire && out_last;
    done_id_d    = hold_id_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = IN_data;
      hold_id_d    = IN_id;
      hold_last_d  = IN_last;
      hold_words_d = words_in;
      sub_idx_d    = '0;
    end else if (fire) begin
      if (final_sub) hold_valid_d = 1'b0;
      else           sub_idx_d    = sub_idx_q + ONE;
    end
  end

  // Control registers: reset brings the block back to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_words_q <= MAXWORDS;
      sub_idx_q    <= '0;
      done_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_words_q <= hold_words_d;
      sub_idx_q    <= sub_idx_d;
      done_valid_q <= done_valid_d;
    end
  end

  // Payload registers: only meaningful while qualified by a valid.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    hold_id_q   <= hold_id_d;
    hold_last_q <= hold_last_d;
    done_id_q   <= done_id_d;
  end

  assign OUT_ready     = out_ready;
  assign OUT_valid     = hold_valid_q;
  assign OUT_data      = out_data;
  assign OUT_id        = hold_id_q;
  assign OUT_last      = out_last;
  assign OUT_doneValid = done_valid_q;
  assign OUT_doneId    = done_id_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (IWIDTH % OWIDTH == 0)
        else $error("IWIDTH must be a multiple of OWIDTH");
      if (accept) begin
        assert (words_in >= ONE && words_in <= MAXWORDS)
          else $error("sub-word count out of range on load");
      end
`ifdef CACHE_READ_SERIALIZER_PARTIAL_EN
      if (IN_valid) begin
        assert (IN_words != '0) else $error("IN_words of zero is illegal");
      end
`endif
      assert (!(fire && !hold_valid_q)) else $error("fire without a held word");
    end
  end
`endif

endmodule

// File: tb/tb_cache_read_serializer.sv
// Directed bench for cache_read_serializer: serialization order, back-to-back handoff, stalls, done pulses, reset.
module tb_cache_read_serializer;
  localparam int IWIDTH = 128;
  localparam int OWIDTH = 32;
  localparam int ID_LEN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              IN_valid;
  logic              OUT_ready;
  logic [ID_LEN-1:0] IN_id;
  logic [IWIDTH-1:0] IN_data;
  logic              IN_last;
`ifdef CACHE_READ_SERIALIZER_PARTIAL_EN
  logic [2:0]        IN_words;
`endif
  logic              IN_ready;
  logic              OUT_valid;
  logic [ID_LEN-1:0] OUT_id;
  logic [OWIDTH-1:0] OUT_data;
  logic              OUT_last;
  logic              OUT_doneValid;
  logic [ID_LEN-1:0] OUT_doneId;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sub_a [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] sub_b [4] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
  logic [31:0] sub_c [4] = '{32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3};

  cache_read_serializer #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .ID_LEN(ID_LEN)) dut (
    .clk(clk), .rst(rst), .IN_valid(IN_valid), .OUT_ready(OUT_ready),
    .IN_id(IN_id), .IN_data(IN_data), .IN_last(IN_last),
`ifdef CACHE_READ_SERIALIZER_PARTIAL_EN
    .IN_words(IN_words),
`endif
    .IN_ready(IN_ready), .OUT_valid(OUT_valid), .OUT_id(OUT_id),
    .OUT_data(OUT_data), .OUT_last(OUT_last),
    .OUT_doneValid(OUT_doneValid), .OUT_doneId(OUT_doneId)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; IN_valid = 1'b0; IN_id = '0; IN_data = '0; IN_last = 1'b0; IN_ready = 1'b1;
`ifdef CACHE_READ_SERIALIZER_PARTIAL_EN
    IN_words = 3'd4;
`endif
    step(); step();
    rst = 1'b0;
    chk("reset_valid", OUT_valid, 1'b0);
    chk("reset_done", OUT_doneValid, 1'b0);
    chk("reset_ready", OUT_ready, 1'b1);

    // Single word, id 2, last
    IN_valid = 1'b1; IN_id = 2'd2; IN_last = 1'b1;
    IN_data = 128'h44444444_33333333_22222222_11111111;
    chk("t1_ready_accept", OUT_ready, 1'b1);
    step();
    IN_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", OUT_valid, 1'b1);
      chk("t1_data", OUT_data, sub_a[k]);
      chk("t1_id", OUT_id, 2'd2);
      chk("t1_last", OUT_last, (k == 3) ? 1'b1 : 1'b0);
      chk("t1_ready", OUT_ready, (k == 3) ? 1'b1 : 1'b0);
      chk("t1_nodone", OUT_doneValid, 1'b0);
      step();
    end
    chk("t1_valid_end", OUT_valid, 1'b0);
    chk("t1_done", OUT_doneValid, 1'b1);
    chk("t1_done_id", OUT_doneId, 2'd2);
    step();
    chk("t1_done_clear", OUT_doneValid, 1'b0);

    // Two words back-to-back, id 1: last=0 then last=1
    IN_valid = 1'b1; IN_id = 2'd1; IN_last = 1'b0;
    IN_data = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    step();
    IN_last = 1'b1;
    IN_data = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    for (int k = 0; k < 4; k++) begin
      chk("t2a_valid", OUT_valid, 1'b1);
      chk("t2a_data", OUT_data, sub_b[k]);
      chk("t2a_last", OUT_last, 1'b0);
      chk("t2a_ready", OUT_ready, (k == 3) ? 1'b1 : 1'b0);
      chk("t2a_nodone", OUT_doneValid, 1'b0);
      step();
    end
    IN_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2b_valid", OUT_valid, 1'b1);
      chk("t2b_data", OUT_data, sub_c[k]);
      chk("t2b_last", OUT_last, (k == 3) ? 1'b1 : 1'b0);
      chk("t2b_nodone", OUT_doneValid, 1'b0);
      step();
    end
    chk("t2_done", OUT_doneValid, 1'b1);
    chk("t2_done_id", OUT_doneId, 2'd1);
    step();
    chk("t2_done_once", OUT_doneValid, 1'b0);

    // Stall pattern 1,0,0,1 on a word with id 3
    IN_valid = 1'b1; IN_id = 2'd3; IN_last = 1'b1;
    IN_data = 128'h44444444_33333333_22222222_11111111;
    step();
    IN_valid = 1'b0; IN_ready = 1'b1;
    chk("t3_sub0", OUT_data, 32'h11111111);
    step();
    IN_ready = 1'b0;
    chk("t3_sub1_a", OUT_data, 32'h22222222);
    chk("t3_ready_a", OUT_ready, 1'b0);
    step();
    chk("t3_sub1_b", OUT_data, 32'h22222222);
    chk("t3_id_b", OUT_id, 2'd3);
    chk("t3_ready_b", OUT_ready, 1'b0);
    chk("t3_valid_b", OUT_valid, 1'b1);
    step();
    chk("t3_sub1_c", OUT_data, 32'h22222222);
    chk("t3_ready_c", OUT_ready, 1'b0);
    IN_ready = 1'b1;
    step();
    chk("t3_sub2", OUT_data, 32'h33333333);
    step();
    chk("t3_sub3", OUT_data, 32'h44444444);
    chk("t3_last", OUT_last, 1'b1);
    step();
    chk("t3_done", OUT_doneValid, 1'b1);
    chk("t3_done_id", OUT_doneId, 2'd3);
    step();

    // Two single-word transfers, id 0 then id 3
    IN_valid = 1'b1; IN_id = 2'd0; IN_last = 1'b1;
    IN_data = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    step();
    IN_id = 2'd3;
    IN_data = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    for (int k = 0; k < 4; k++) begin
      chk("t4a_data", OUT_data, sub_b[k]);
      chk("t4a_id", OUT_id, 2'd0);
      step();
    end
    IN_valid = 1'b0;
    chk("t4_done0", OUT_doneValid, 1'b1);
    chk("t4_done0_id", OUT_doneId, 2'd0);
    chk("t4b_data0", OUT_data, sub_c[0]);
    chk("t4b_id", OUT_id, 2'd3);
    step();
    chk("t4_done_gap", OUT_doneValid, 1'b0);
    step(); step(); step();
    chk("t4_done3", OUT_doneValid, 1'b1);
    chk("t4_done3_id", OUT_doneId, 2'd3);
    chk("t4_idle", OUT_valid, 1'b0);
    step();

    // Reset after the second sub-beat of a word
    IN_valid = 1'b1; IN_id = 2'd2; IN_last = 1'b1;
    IN_data = 128'h44444444_33333333_22222222_11111111;
    step();
    IN_valid = 1'b0;
    step();
    chk("t5_sub1", OUT_data, 32'h22222222);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", OUT_valid, 1'b0);
    chk("t5_done", OUT_doneValid, 1'b0);
    IN_valid = 1'b1; IN_id = 2'd1; IN_last = 1'b1;
    IN_data = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    step();
    IN_valid = 1'b0;
    chk("t5_fresh_valid", OUT_valid, 1'b1);
    chk("t5_fresh_sub0", OUT_data, 32'hB0B0B0B0);
    chk("t5_fresh_nodone", OUT_doneValid, 1'b0);
    step(); step(); step(); step();
    chk("t5_fresh_done_id", OUT_doneId, 2'd1);
    chk("t5_fresh_done", OUT_doneValid, 1'b1);
    step();

`ifdef CACHE_READ_SERIALIZER_PARTIAL_EN
    // Partial word: a single valid sub-word
    IN_valid = 1'b1; IN_id = 2'd2; IN_last = 1'b1; IN_words = 3'd1;
    IN_data = 128'h0;
    IN_data[31:0] = 32'hDEADBEEF;
    step();
    IN_valid = 1'b0; IN_words = 3'd4;
    chk("p_data", OUT_data, 32'hDEADBEEF);
    chk("p_last", OUT_last, 1'b1);
    chk("p_ready", OUT_ready, 1'b1);
    step();
    chk("p_valid_end", OUT_valid, 1'b0);
    chk("p_done", OUT_doneValid, 1'b1);
    chk("p_done_id", OUT_doneId, 2'd2);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
